// File: rtl/pipe_stall_sched_if.sv
// Handshake bundle between the pipeline stages and the stall/flush scheduler.
// Perf counter signals exist only when STALL_PERF_EN is defined.
interface pipe_stall_sched_if #(
    parameter int unsigned CNT_W = 2
);
    logic             hazard_req;
    logic [CNT_W-1:0] hazard_cycles;
    logic             branch_taken;
    logic             div_start;
    logic             div_done;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_clr;
    logic             id_exe_we;
    logic             id_exe_clr;
    logic             exe_mem_clr;
    logic [1:0]       sched_state;
    logic             div_err;
`ifdef STALL_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_flush_cnt;
    logic [15:0]      perf_div_cnt;
`endif

    modport master (
        output hazard_req, hazard_cycles, branch_taken, div_start, div_done,
        input  pc_we, if_id_we, if_id_clr, id_exe_we, id_exe_clr, exe_mem_clr,
        input  sched_state, div_err
`ifdef STALL_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt, perf_div_cnt
`endif
    );

    modport slave (
        input  hazard_req, hazard_cycles, branch_taken, div_start, div_done,
        output pc_we, if_id_we, if_id_clr, id_exe_we, id_exe_clr, exe_mem_clr,
        output sched_state, div_err
`ifdef STALL_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt, perf_div_cnt
`endif
    );
endinterface

// File: rtl/pipe_stall_sched.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates divider, branch and load-use
// requests into Mealy per-stage enables/clears. Optional perf counters under STALL_PERF_EN.
module pipe_stall_sched #(
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    pipe_stall_sched_if.slave bus
);
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StDivWait = 2'd2
    } sched_state_e;

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_nxt;
    logic             r_div_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_n;
    logic             w_div_acc;

    logic w_pc_we, w_if_id_we, w_if_id_clr, w_id_exe_we, w_id_exe_clr, w_exe_mem_clr;

    // A zero bubble request still costs one stall cycle.
    assign w_n = (bus.hazard_cycles == '0) ? CNT_W'(1) : bus.hazard_cycles;

    always_comb begin
        w_pc_we       = 1'b1;
        w_if_id_we    = 1'b1;
        w_if_id_clr   = 1'b0;
        w_id_exe_we   = 1'b1;
        w_id_exe_clr  = 1'b0;
        w_exe_mem_clr = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_err_nxt     = r_div_err;
        w_div_acc     = 1'b0;
        case (r_state)
            StRun: begin
                if (bus.div_start) begin
                    w_pc_we       = 1'b0;
                    w_if_id_we    = 1'b0;
                    w_id_exe_we   = 1'b0;
                    w_exe_mem_clr = 1'b1;
                    w_div_acc     = 1'b1;
                    w_wait_nxt    = '0;
                    if (!bus.div_done) begin
                        w_state_nxt = StDivWait;
                    end
                end else if (bus.branch_taken) begin
                    w_if_id_clr = 1'b1;
                end else if (bus.hazard_req) begin
                    w_pc_we      = 1'b0;
                    w_if_id_we   = 1'b0;
                    w_id_exe_clr = 1'b1;
                    if (w_n != CNT_W'(1)) begin
                        w_cnt_nxt   = w_n - CNT_W'(1);
                        w_state_nxt = StLuStall;
                    end
                end
            end
            StLuStall: begin
                if (bus.div_start) begin
                    w_pc_we       = 1'b0;
                    w_if_id_we    = 1'b0;
                    w_id_exe_we   = 1'b0;
                    w_exe_mem_clr = 1'b1;
                    w_div_acc     = 1'b1;
                    w_cnt_nxt     = '0;
                    w_wait_nxt    = '0;
                    w_state_nxt   = StDivWait;
                end else begin
                    w_pc_we      = 1'b0;
                    w_if_id_we   = 1'b0;
                    w_id_exe_clr = 1'b1;
                    w_cnt_nxt    = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = StRun;
                    end
                end
            end
            StDivWait: begin
                w_pc_we       = 1'b0;
                w_if_id_we    = 1'b0;
                w_id_exe_we   = 1'b0;
                w_exe_mem_clr = 1'b1;
                if (bus.div_done) begin
                    w_state_nxt = StRun;
                end else if (r_wait_cnt == 8'(DIV_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = StRun;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StRun;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            r_div_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_div_err  <= w_err_nxt;
        end
    end

    // Reset holds every stage frozen and bubbled, independent of state.
    assign bus.pc_we       = rst & w_pc_we;
    assign bus.if_id_we    = rst & w_if_id_we;
    assign bus.id_exe_we   = rst & w_id_exe_we;
    assign bus.if_id_clr   = ~rst | w_if_id_clr;
    assign bus.id_exe_clr  = ~rst | w_id_exe_clr;
    assign bus.exe_mem_clr = ~rst | w_exe_mem_clr;
    assign bus.sched_state = r_state;
    assign bus.div_err     = r_div_err;

`ifdef STALL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [15:0] r_perf_div;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_div   <= '0;
        end else begin
            if (!w_pc_we && r_perf_stall != '1) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_if_id_clr && r_perf_flush != '1) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (w_div_acc && r_perf_div != '1) begin
                r_perf_div <= r_perf_div + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall;
    assign bus.perf_flush_cnt = r_perf_flush;
    assign bus.perf_div_cnt   = r_perf_div;
`endif
endmodule

// File: doc/pipe_stall_sched.md
Name: pipe_stall_sched

Overview:
- Central stall/flush scheduler for the 5-stage dynamic pipeline (IF/ID/EXE/MEM/WB).
- Inputs:
  - load-use hazard request from IF-stage conflict detection
  - taken-branch indication from ID
  - multi-cycle divider handshake from EXE
- Arbitrates the three sources and sequences them over multiple cycles.
- Drives per-stage write-enable / clear controls for PC, IF/ID, ID/EXE and EXE/MEM registers.

Parameters:
- CNT_W, 2, width of hazard_cycles; maximum bubble count is 2^CNT_W-1.
- DIV_TIMEOUT, 64, cycles in DIV_WAIT before forced abort (range 2..255).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- hazard_req  in  1  load-use conflict on instruction currently in IF.
- hazard_cycles  in  CNT_W  bubble cycles required; 0 treated as 1.
- branch_taken  in  1  branch/jump in ID resolved taken this cycle.
- div_start  in  1  level request from EXE, held until accepted.
- div_done  in  1  divider result valid (single-cycle pulse).
- pc_we  out  1  PC register write enable.
- if_id_we  out  1  IF/ID register write enable.
- if_id_clr  out  1  IF/ID synchronous clear (inject nop).
- id_exe_we  out  1  ID/EXE register write enable.
- id_exe_clr  out  1  ID/EXE clear (bubble).
- exe_mem_clr  out  1  EXE/MEM clear (bubble).
- sched_state  out  2  current state encoding (RUN=0, LU_STALL=1, DIV_WAIT=2).
- div_err  out  1  sticky divider-timeout flag.

Behaviour:
- Outputs are Mealy: combinational from state and current inputs, so a stall takes effect in the same cycle the request appears.
- Default (RUN, no request): pc_we=if_id_we=id_exe_we=1, all *_clr=0.
- Reset:
  - While rst=0 at a clock edge: state<=RUN, cnt<=0, wait_cnt<=0, div_err<=0.
  - While rst=0, outputs forced to: all *_we=0, all *_clr=1.
  - Reset mid-stall or mid-DIV_WAIT abandons the sequence with no residual stall.
- RUN priority: div_start > branch_taken > hazard_req.
  - div_start: freeze this cycle (pc_we=if_id_we=id_exe_we=0, exe_mem_clr=1); next state DIV_WAIT; wait_cnt<=0. If div_done is also high this cycle, stay RUN (zero-wait divide).
  - branch_taken: if_id_clr=1, pc_we=1, if_id_we=1 for exactly one cycle; hazard_req in the same cycle is ignored (the IF instruction is being squashed).
  - hazard_req: pc_we=0, if_id_we=0, id_exe_clr=1. Let n=max(hazard_cycles,1). If n==1, stay RUN; else cnt<=n-1 and go to LU_STALL.
- LU_STALL:
  - Outputs identical to the RUN hazard case.
  - cnt decrements each cycle; when cnt==1, next state RUN.
  - Total stalled cycles = n exactly.
  - branch_taken and hazard_req are ignored.
  - div_start preempts: divider freeze outputs, cnt<=0, next DIV_WAIT.
- DIV_WAIT:
  - Freeze outputs every cycle.
  - branch_taken and hazard_req are ignored; they are re-evaluated in RUN.
  - div_done=1: freeze still applied this cycle; next state RUN.
  - wait_cnt increments each cycle. When wait_cnt==DIV_TIMEOUT-1 without div_done: div_err<=1, next RUN.
  - div_err clears only on reset.
- Any unused sched_state encoding (3) returns to RUN next cycle; outputs meanwhile as in RUN default.

Optional Feature:
- Macro STALL_PERF_EN.
- When defined, adds three outputs, each saturating at all-ones and cleared by reset:
  - perf_stall_cnt [31:0]: counts cycles with pc_we=0 outside reset.
  - perf_flush_cnt [31:0]: counts cycles with if_id_clr=1 outside reset.
  - perf_div_cnt [15:0]: counts accepted div_start.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 for 3 cycles with hazard_req=1 -> pc_we=0, if_id_clr=1, id_exe_clr=1, exe_mem_clr=1 throughout. After rst=1 with no requests: sched_state=0, pc_we=1.
- Load-use: hazard_req=1, hazard_cycles=3 for one cycle, then 0 -> pc_we=0 for exactly 3 consecutive cycles, then 1; sched_state sequence 0,1,1,0. hazard_cycles=0 -> single stall cycle.
- Branch vs hazard: branch_taken=1 and hazard_req=1 same cycle -> if_id_clr=1, pc_we=1, id_exe_clr=0, sched_state stays 0.
- Divider: div_start held high, div_done pulses 5 cycles later -> freeze for 6 cycles total, id_exe_we=0; sched_state returns to 0 the cycle after div_done; div_err=0. div_start with div_done in the same cycle -> 1-cycle freeze, state stays 0.
- Timeout: DIV_TIMEOUT=8, div_start with no div_done -> div_err=1 after 8 DIV_WAIT cycles; returns to RUN; div_err remains 1 until rst=0.
- Preemption: hazard_cycles=3 stall in progress, div_start at the 2nd cycle -> DIV_WAIT entered next cycle; no load-use stall cycles resume after div_done. With STALL_PERF_EN: perf_div_cnt=1.
